// File: rtl/t03_memory_arbiter.sv
// Merges the CPU fetch and load/store ports into one single-request stream for the bus manager.
// A single-entry fetch buffer answers a repeated fetch of the same word without a bus cycle.
module t03_memory_arbiter #(
  parameter bit          IBUF_EN  = 1'b1,
  parameter logic [31:0] BAD_DATA = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        i_flush,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_sel,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mgr_read,
  output logic        mgr_write,
  output logic [31:0] mgr_adr,
  output logic [31:0] mgr_wdata,
  output logic [3:0]  mgr_sel,
  input  logic [31:0] mgr_rdata,
  input  logic        mgr_busy,
  input  logic        mgr_ack
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitAck, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  sel_q, sel_d;
  logic        write_q, write_d;
  logic        fetch_q, fetch_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        ibuf_valid_q, ibuf_valid_d;
  logic [29:0] ibuf_tag_q, ibuf_tag_d;
  logic [31:0] ibuf_data_q, ibuf_data_d;
  logic        ibuf_hit;
  logic        unused_busy;

  assign unused_busy = mgr_busy;
  assign mgr_adr     = adr_q;
  assign mgr_wdata   = wdata_q;
  assign mgr_sel     = sel_q;
  assign ibuf_hit    = IBUF_EN && ibuf_valid_q && (i_addr[31:2] == ibuf_tag_q) && !i_flush;

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    write_d      = write_q;
    fetch_d      = fetch_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    ibuf_valid_d = ibuf_valid_q;
    ibuf_tag_d   = ibuf_tag_q;
    ibuf_data_d  = ibuf_data_q;
    i_ready      = 1'b0;
    d_ready      = 1'b0;
    i_rdata      = i_rdata_q;
    d_rdata      = d_rdata_q;
    mgr_read     = 1'b0;
    mgr_write    = 1'b0;

    if (i_flush) begin
      ibuf_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (d_read || d_write) begin
          adr_d   = d_addr;
          wdata_d = d_write ? d_wdata : BAD_DATA;
          sel_d   = d_sel;
          write_d = d_write;
          fetch_d = 1'b0;
          state_d = StIssue;
        end else if (i_req) begin
          if (ibuf_hit) begin
            i_ready   = 1'b1;
            i_rdata   = ibuf_data_q;
            i_rdata_d = ibuf_data_q;
          end else begin
            adr_d   = {i_addr[31:2], 2'b00};
            wdata_d = BAD_DATA;
            sel_d   = 4'hF;
            write_d = 1'b0;
            fetch_d = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        mgr_read  = !write_q;
        mgr_write = write_q;
        state_d   = StWaitAck;
      end
      StWaitAck: begin
        if (mgr_ack) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
        if (fetch_q) begin
          i_ready   = 1'b1;
          i_rdata   = mgr_rdata;
          i_rdata_d = mgr_rdata;
          // A fill overrides a same-cycle flush.
          if (IBUF_EN) begin
            ibuf_valid_d = 1'b1;
            ibuf_tag_d   = adr_q[31:2];
            ibuf_data_d  = mgr_rdata;
          end
        end else begin
          d_ready = 1'b1;
          if (write_q) begin
            if (adr_q[31:2] == ibuf_tag_q) begin
              ibuf_valid_d = 1'b0;
            end
          end else begin
            d_rdata   = mgr_rdata;
            d_rdata_d = mgr_rdata;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StIdle;
      adr_q        <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      write_q      <= 1'b0;
      fetch_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      ibuf_valid_q <= 1'b0;
      ibuf_tag_q   <= '0;
      ibuf_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      write_q      <= write_d;
      fetch_q      <= fetch_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      ibuf_valid_q <= ibuf_valid_d;
      ibuf_tag_q   <= ibuf_tag_d;
      ibuf_data_q  <= ibuf_data_d;
    end
  end

endmodule
